// File: rtl/tdc_measure_ctrl_if.sv
// Control/readout bundle of the TDC measurement sequencer: start request, tap
// snapshot bus and the timestamp valid/ready handshake.
interface tdc_measure_ctrl_if #(
  parameter int NUM      = 12,
  parameter int BIN_W    = 4,
  parameter int COARSE_W = 16
);
  logic                iStart;
  logic [NUM-1:0]      iFF;
  logic                iReady;
  logic                oArm;
  logic                oBusy;
  logic                oValid;
  logic [COARSE_W-1:0] oCoarse;
  logic [BIN_W-1:0]    oFine;
  logic                oTimeout;

  modport slave (
    input  iStart, iFF, iReady,
    output oArm, oBusy, oValid, oCoarse, oFine, oTimeout
  );

  modport master (
    output iStart, iFF, iReady,
    input  oArm, oBusy, oValid, oCoarse, oFine, oTimeout
  );
endinterface

// File: rtl/tdc_measure_ctrl.sv
// Tapped-delay-line TDC sequencer: arms the line, waits for the hit (or a
// timeout), freezes the tap snapshot and coarse count, then reports a timestamp.
module tdc_measure_ctrl #(
  parameter int NUM      = 12,
  parameter int BIN_W    = 4,
  parameter int COARSE_W = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                  iClk,
  input  logic                  iRst,
  tdc_measure_ctrl_if.slave     bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [COARSE_W-1:0] LAST_CNT = COARSE_W'(TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic [COARSE_W-1:0] cnt_q, cnt_d;
  logic [NUM-1:0]      snap_q, snap_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [BIN_W-1:0]    fine_q, fine_d;
  logic                timeout_q, timeout_d;
  logic                arm_q, busy_q, valid_q;

  // Popcount of the frozen snapshot as a ripple of prefix sums; a bubble in the
  // thermometer code then moves the result by at most one bin.
  logic [BIN_W-1:0] psum [NUM+1];
  assign psum[0] = '0;
  for (genvar gi = 0; gi < NUM; gi++) begin : g_pop
    assign psum[gi+1] = psum[gi] + BIN_W'(snap_q[gi]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          cnt_d   = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A hit takes priority over an expiring timeout in the same cycle.
        if (bus.iFF[0]) begin
          snap_d   = bus.iFF;
          coarse_d = cnt_q;
          state_d  = ST_DECODE;
        end else if (cnt_q == LAST_CNT) begin
          timeout_d = 1'b1;
          coarse_d  = LAST_CNT;
          fine_d    = '0;
          state_d   = ST_REPORT;
        end else begin
          cnt_d = cnt_q + COARSE_W'(1);
        end
      end
      ST_DECODE: begin
        fine_d    = psum[NUM];
        timeout_d = 1'b0;
        state_d   = ST_REPORT;
      end
      ST_REPORT: begin
        if (bus.iReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      snap_q    <= '0;
      coarse_q  <= '0;
      fine_q    <= '0;
      timeout_q <= 1'b0;
      arm_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      timeout_q <= timeout_d;
      arm_q     <= (state_d == ST_ARMED);
      busy_q    <= (state_d != ST_IDLE);
      valid_q   <= (state_d == ST_REPORT);
    end
  end

  assign bus.oArm     = arm_q;
  assign bus.oBusy    = busy_q;
  assign bus.oValid   = valid_q;
  assign bus.oCoarse  = coarse_q;
  assign bus.oFine    = fine_q;
  assign bus.oTimeout = timeout_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Randomised scoreboard bench for tdc_measure_ctrl: stimulus queues expected
// timestamps, a monitor drives iReady and checks every presented result.
module tb_tdc_measure_ctrl;
  localparam int NUM = 12;
  localparam int BW  = 4;
  localparam int CW  = 16;
  localparam int TMO = 8;

  typedef struct {
    logic [CW-1:0] coarse;
    logic [BW-1:0] fine;
    logic          to;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_measure_ctrl_if #(.NUM(NUM), .BIN_W(BW), .COARSE_W(CW)) bus ();

  tdc_measure_ctrl #(.NUM(NUM), .BIN_W(BW), .COARSE_W(CW), .TIMEOUT(TMO)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic last_edge_rst = 1'b1;
  int   ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit   b2b = 1'b0;
  res_t exp_q[$];

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    last_edge_rst <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: first ARMED cycle with tap 0 set decides the timestamp.
  function automatic res_t model(input int h, input logic [NUM-1:0] hv);
    res_t r;
    if (h < TMO) begin
      r.coarse = CW'(h);
      r.fine   = BW'($countones(hv));
      r.to     = 1'b0;
    end else begin
      r.coarse = CW'(TMO - 1);
      r.fine   = '0;
      r.to     = 1'b1;
    end
    return r;
  endfunction

  // Monitor: decides iReady, checks hold stability and pops on each accept.
  initial begin
    logic          pv, pr, r, pt;
    logic [CW-1:0] pc;
    logic [BW-1:0] pf;
    int            last_acc;
    res_t          e;
    pv = 1'b0; pr = 1'b0; pt = 1'b0; pc = '0; pf = '0; last_acc = -1;
    bus.iReady = 1'b0;
    forever begin
      @(negedge clk);
      if (!b2b) last_acc = -1;
      if (!last_edge_rst && pv && !pr) begin
        chk("hold_valid",   32'(bus.oValid),   32'(1'b1));
        chk("hold_coarse",  32'(bus.oCoarse),  32'(pc));
        chk("hold_fine",    32'(bus.oFine),    32'(pf));
        chk("hold_timeout", 32'(bus.oTimeout), 32'(pt));
      end
      if (bus.oValid) begin
        case (ready_mode)
          0:       r = 1'($urandom_range(0, 1));
          1:       r = 1'b1;
          default: r = 1'b0;
        endcase
        bus.iReady = r;
        if (r) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got result coarse=%0d fine=%0d to=%0b, required none",
                     bus.oCoarse, bus.oFine, bus.oTimeout);
          end else begin
            e = exp_q.pop_front();
            chk("coarse",  32'(bus.oCoarse),  32'(e.coarse));
            chk("fine",    32'(bus.oFine),    32'(e.fine));
            chk("timeout", 32'(bus.oTimeout), 32'(e.to));
            $display("result coarse=%0d fine=%0d timeout=%0b", bus.oCoarse, bus.oFine, bus.oTimeout);
            if (b2b) begin
              if (last_acc >= 0) chk("b2b_period", 32'(cyc - last_acc), 32'd4);
              last_acc = cyc;
            end
          end
        end
      end else begin
        bus.iReady = 1'($urandom_range(0, 1));
      end
      pv = bus.oValid; pr = bus.iReady;
      pc = bus.oCoarse; pf = bus.oFine; pt = bus.oTimeout;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.oBusy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", 32'(bus.oBusy), 32'(1'b0));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (bus.oValid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_valid", 32'(bus.oValid), 32'(1'b1));
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({bus.oArm, bus.oBusy, bus.oValid, bus.oCoarse, bus.oFine, bus.oTimeout}), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns once the hit/timeout edge passed.
  task automatic start_meas(input int h, input logic [NUM-1:0] hv, input bit push);
    logic [NUM-1:0] v;
    if (push) exp_q.push_back(model(h, hv));
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      if (c == h) begin
        bus.iFF = hv;
        @(negedge clk);
        break;
      end
      v = NUM'($urandom);
      v[0] = 1'b0;
      bus.iFF = v;
      @(negedge clk);
    end
    bus.iFF = NUM'($urandom);
  endtask

  initial begin
    logic [NUM-1:0] hv;
    int h;
    bus.iStart = 1'b0;
    bus.iFF    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    ready_mode = 1;
    start_meas(4, 12'h03F, 1'b1);
    chk("latency_decode", 32'(bus.oValid), 32'(1'b0));
    @(negedge clk);
    chk("latency_report", 32'(bus.oValid), 32'(1'b1));
    wait_idle();
    start_meas(0, 12'hFFF, 1'b1); wait_idle();
    start_meas(2, 12'h0F7, 1'b1); wait_idle();
    start_meas(99, 12'h000, 1'b1); wait_idle();
    hv = NUM'($urandom) | NUM'(1);
    start_meas(7, hv, 1'b1); wait_idle();

    // Stalled report: outputs hold, iStart and iFF are ignored
    ready_mode = 2;
    start_meas(3, 12'h01F, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      bus.iFF    = NUM'($urandom);
      bus.iStart = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("no_rearm", 32'({bus.oArm, bus.oBusy, bus.oValid}), 32'(3'b011));
    end
    bus.iStart = 1'b0;
    ready_mode = 1;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset during ARMED
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    bus.iFF = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_armed");
    rst = 1'b0;
    @(negedge clk);

    // Reset during REPORT: the pending result is discarded
    ready_mode = 2;
    start_meas(2, 12'h00F, 1'b1);
    wait_valid();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_report");
    void'(exp_q.pop_back());
    rst = 1'b0;
    ready_mode = 1;
    repeat (3) @(negedge clk);
    chk("no_valid_after_rst", 32'(bus.oValid), 32'(1'b0));
    start_meas(5, 12'h07F, 1'b1); wait_idle();

    // Random measurements, random consumer
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      h  = int'($urandom_range(0, TMO + 1));
      hv = NUM'($urandom) | NUM'(1);
      start_meas(h, hv, 1'b1);
      wait_idle();
    end

    // Back-to-back: iStart held, hit on first ARMED cycle, always ready
    ready_mode = 1;
    repeat (2) @(negedge clk);
    b2b = 1'b1;
    hv = NUM'($urandom) | NUM'(1);
    for (int i = 0; i < 5; i++) exp_q.push_back(model(0, hv));
    bus.iFF    = hv;
    bus.iStart = 1'b1;
    repeat (20) @(negedge clk);
    bus.iStart = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    b2b = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
